intdiv_abs_seq: RTL and testbench

//  Digit-serial absolute-value/sign-detect sequencer for the divider front end. Accepts a redundant operand
//  (partial-sum ps, transfer tr bit vectors, digit i = ps[i]-tr[i]), walks digits MSB-first through one

---
 rtl/intdiv_abs_seq_pkg.sv | 25 ++
 rtl/intdiv_abs.sv | 41 ++++
 rtl/intdiv_abs_seq.sv | 125 ++++++++++++
 tb/tb_intdiv_abs_seq.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/intdiv_abs_seq_pkg.sv
// Purpose: shared SD2 digit encodings and sequencer state codes for the abs/sign front end.
// Latency: n/a (constants, types and a helper function only).
// Backpressure: n/a.
package intdiv_abs_seq_pkg;

   // SD2 (p,n) digit encoding, value = p - n
   localparam logic [1:0] POS1      = 2'b10;
   localparam logic [1:0] NEG1      = 2'b01;
   localparam logic [1:0] ZERO_1    = 2'b00;
   localparam logic [1:0] ZERO_2    = 2'b11;
   // Value the cell drives when its inputs are meaningless (zero digit, no sign yet)
   localparam logic [1:0] DONTCARES = 2'b11;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } seq_state_t;

   // True for either encoding of a zero digit
   function automatic logic sd2_is_zero(input logic [1:0] d);
      return d[1] == d[0];
   endfunction

endpackage

// File: rtl/intdiv_abs.sv
// Purpose: one-digit MSB-first absolute-value cell; first nonzero digit fixes the sign, later digits follow it.
// Latency: combinational.
// Backpressure: none; driven one digit per cycle by the sequencer.
module intdiv_abs
   import intdiv_abs_seq_pkg::*;
(
   input  logic       ps,
   input  logic       tr,
   input  logic [1:0] sign_in,
   output logic [1:0] res,
   output logic [1:0] sign_out
);

   logic [1:0] digit;

   assign digit = {ps, tr};

   // Positive sign passes digits through, negative sign swaps p/n, undecided sign takes the digit's sign.
   // Zero digit with undecided sign has no defined result; the caller bypasses that case.
   always_comb begin
      res      = DONTCARES;
      sign_out = DONTCARES;
      case (sign_in)
         POS1: begin
            res      = digit;
            sign_out = POS1;
         end
         NEG1: begin
            res      = {tr, ps};
            sign_out = NEG1;
         end
         default: begin
            if (!sd2_is_zero(digit)) begin
               res      = POS1;
               sign_out = digit;
            end
         end
      endcase
   end

endmodule

// File: rtl/intdiv_abs_seq.sv
// Purpose: digit-serial |x| and sign of a redundant (ps,tr) operand through a single intdiv_abs cell.
// Latency: out_valid rises exactly N cycles after the accepting edge; one operand per N+2 cycles at best.
// Backpressure: result held in DONE until out_ready; in_ready is low outside IDLE.
module intdiv_abs_seq
   import intdiv_abs_seq_pkg::*;
#(
   parameter int N = 8
)(
   input  logic           clk,
   input  logic           rst,
   input  logic           in_valid,
   output logic           in_ready,
   input  logic [N-1:0]   in_ps,
   input  logic [N-1:0]   in_tr,
   output logic           out_valid,
   input  logic           out_ready,
   output logic [2*N-1:0] out_mag,
   output logic [1:0]     out_sign,
   output logic           out_zero
);

   localparam int CNT_W = $clog2(N);
   localparam logic [CNT_W-1:0] IDX_TOP = CNT_W'(N - 1);

   seq_state_t       state_q;
   seq_state_t       state_d;
   logic [N-1:0]     ps_q;
   logic [N-1:0]     tr_q;
   logic [CNT_W-1:0] idx_q;
   logic [1:0]       sign_q;

   logic             cur_ps;
   logic             cur_tr;
   logic [1:0]       cell_res;
   logic [1:0]       cell_sign;
   logic             bypass;
   logic [1:0]       res_d;
   logic [1:0]       sign_d;
   logic             accept;
   logic             idx_last;

   assign cur_ps   = ps_q[idx_q];
   assign cur_tr   = tr_q[idx_q];
   assign idx_last = (idx_q == '0);
   assign accept   = (state_q == IDLE) && in_valid;

   intdiv_abs u_abs (
      .ps       (cur_ps),
      .tr       (cur_tr),
      .sign_in  (sign_q),
      .res      (cell_res),
      .sign_out (cell_sign)
   );

   // Leading zero digits never reach the cell; cell ZERO_2 results are folded to ZERO_1
   always_comb begin
      bypass = (sign_q == ZERO_1) && (cur_ps == cur_tr);
      res_d  = ZERO_1;
      sign_d = sign_q;
      if (!bypass) begin
         res_d  = (cell_res == ZERO_2) ? ZERO_1 : cell_res;
         sign_d = cell_sign;
      end
   end

   // State register
   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // Next-state and handshake outputs
   always_comb begin
      state_d   = state_q;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      case (state_q)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) state_d = RUN;
         end
         RUN: begin
            if (idx_last) state_d = DONE;
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Operand capture, digit walk and result registers
   always_ff @(posedge clk) begin
      if (rst) begin
         ps_q     <= '0;
         tr_q     <= '0;
         idx_q    <= IDX_TOP;
         sign_q   <= ZERO_1;
         out_mag  <= '0;
         out_sign <= ZERO_1;
         out_zero <= 1'b0;
      end else begin
         if (accept) begin
            ps_q   <= in_ps;
            tr_q   <= in_tr;
            sign_q <= ZERO_1;
            idx_q  <= IDX_TOP;
         end
         if (state_q == RUN) begin
            for (int i = 0; i < N; i++) begin
               if (idx_q == CNT_W'(i)) out_mag[2*i +: 2] <= res_d;
            end
            sign_q <= sign_d;
            if (idx_last) begin
               out_sign <= sign_d;
               out_zero <= (sign_d == ZERO_1);
            end else begin
               idx_q <= idx_q - CNT_W'(1);
            end
         end
      end
   end

endmodule

// File: tb/tb_intdiv_abs_seq.sv
module tb_intdiv_abs_seq;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst;

   logic       in_valid4, in_ready4, out_valid4, out_ready4, out_zero4;
   logic [3:0] in_ps4, in_tr4;
   logic [7:0] out_mag4;
   logic [1:0] out_sign4;

   logic        in_valid8, in_ready8, out_valid8, out_ready8, out_zero8;
   logic [7:0]  in_ps8, in_tr8;
   logic [15:0] out_mag8;
   logic [1:0]  out_sign8;

   int checks = 0;
   int errors = 0;

   intdiv_abs_seq #(.N(4)) dut4 (
      .clk(clk), .rst(rst),
      .in_valid(in_valid4), .in_ready(in_ready4), .in_ps(in_ps4), .in_tr(in_tr4),
      .out_valid(out_valid4), .out_ready(out_ready4),
      .out_mag(out_mag4), .out_sign(out_sign4), .out_zero(out_zero4)
   );

   intdiv_abs_seq #(.N(8)) dut8 (
      .clk(clk), .rst(rst),
      .in_valid(in_valid8), .in_ready(in_ready8), .in_ps(in_ps8), .in_tr(in_tr8),
      .out_valid(out_valid8), .out_ready(out_ready8),
      .out_mag(out_mag8), .out_sign(out_sign8), .out_zero(out_zero8)
   );

   // Present one operand to the N=4 instance (IDLE assumed), return #1 after the accepting edge
   task automatic send4(input logic [3:0] ps, input logic [3:0] tr);
      @(negedge clk);
      in_ps4 = ps; in_tr4 = tr; in_valid4 = 1'b1;
      @(posedge clk); #1;
      in_valid4 = 1'b0;
   endtask

   // Count edges from the accepting edge until out_valid is seen (bounded)
   task automatic wait_valid4(output int lat);
      lat = 0;
      while (!out_valid4 && lat < 20) begin
         @(posedge clk); #1;
         lat++;
      end
   endtask

   task automatic release4;
      @(negedge clk); out_ready4 = 1'b1;
      @(posedge clk); #1; out_ready4 = 1'b0;
   endtask

   task automatic test_reset;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (in_ready4 !== 1'b1 || out_valid4 !== 1'b0 || out_mag4 !== 8'h00 || out_sign4 !== 2'b00 || out_zero4 !== 1'b0) begin
         errors++;
         $display("FAIL reset4: rdy=%b vld=%b mag=%b sign=%b zero=%b, want rdy=1 vld=0 mag=0 sign=00 zero=0",
                  in_ready4, out_valid4, out_mag4, out_sign4, out_zero4);
      end
      checks++;
      if (in_ready8 !== 1'b1 || out_valid8 !== 1'b0 || out_mag8 !== 16'h0000 || out_sign8 !== 2'b00 || out_zero8 !== 1'b0) begin
         errors++;
         $display("FAIL reset8: rdy=%b vld=%b mag=%h sign=%b zero=%b, want rdy=1 vld=0 mag=0 sign=00 zero=0",
                  in_ready8, out_valid8, out_mag8, out_sign8, out_zero8);
      end
      @(negedge clk); rst = 1'b0;
   endtask

   task automatic test_pos3;
      int lat;
      send4(4'b0100, 4'b0001);
      wait_valid4(lat);
      checks++;
      if (lat !== 4) begin errors++; $display("FAIL pos3_latency: got %0d want 4", lat); end
      checks++;
      if (out_mag4 !== 8'b00_10_00_01) begin errors++; $display("FAIL pos3_mag: got %b want 00100001", out_mag4); end
      checks++;
      if (out_sign4 !== 2'b10 || out_zero4 !== 1'b0) begin
         errors++; $display("FAIL pos3_sign: got sign=%b zero=%b want sign=10 zero=0", out_sign4, out_zero4);
      end
      release4;
      checks++;
      if (out_valid4 !== 1'b0 || in_ready4 !== 1'b1) begin
         errors++; $display("FAIL pos3_release: got vld=%b rdy=%b want vld=0 rdy=1", out_valid4, in_ready4);
      end
   endtask

   task automatic test_neg3;
      int lat;
      send4(4'b0001, 4'b0100);
      wait_valid4(lat);
      checks++;
      if (lat !== 4) begin errors++; $display("FAIL neg3_latency: got %0d want 4", lat); end
      checks++;
      if (out_mag4 !== 8'b00_10_00_01) begin errors++; $display("FAIL neg3_mag: got %b want 00100001", out_mag4); end
      checks++;
      if (out_sign4 !== 2'b01 || out_zero4 !== 1'b0) begin
         errors++; $display("FAIL neg3_sign: got sign=%b zero=%b want sign=01 zero=0", out_sign4, out_zero4);
      end
      release4;
   endtask

   task automatic test_all_zero2;
      int lat;
      send4(4'b1111, 4'b1111);
      wait_valid4(lat);
      checks++;
      if (lat !== 4) begin errors++; $display("FAIL zero2_latency: got %0d want 4", lat); end
      checks++;
      if (out_mag4 !== 8'h00 || out_sign4 !== 2'b00 || out_zero4 !== 1'b1) begin
         errors++; $display("FAIL zero2_result: got mag=%b sign=%b zero=%b want mag=0 sign=00 zero=1",
                            out_mag4, out_sign4, out_zero4);
      end
      checks++;
      if ($isunknown({out_mag4, out_sign4, out_zero4, out_valid4, in_ready4})) begin
         errors++; $display("FAIL zero2_unknown: got mag=%b sign=%b zero=%b want no X", out_mag4, out_sign4, out_zero4);
      end
      release4;
   endtask

   task automatic test_backpressure;
      int lat;
      send4(4'b0100, 4'b0001);
      wait_valid4(lat);
      @(negedge clk);
      in_ps4 = 4'b0001; in_tr4 = 4'b0100; in_valid4 = 1'b1;
      for (int c = 0; c < 10; c++) begin
         @(posedge clk); #1;
         checks++;
         if (out_valid4 !== 1'b1 || in_ready4 !== 1'b0 || out_mag4 !== 8'b00_10_00_01 ||
             out_sign4 !== 2'b10 || out_zero4 !== 1'b0) begin
            errors++;
            $display("FAIL stall_cycle%0d: got vld=%b rdy=%b mag=%b sign=%b zero=%b want vld=1 rdy=0 mag=00100001 sign=10 zero=0",
                     c, out_valid4, in_ready4, out_mag4, out_sign4, out_zero4);
         end
      end
      @(negedge clk); in_valid4 = 1'b0; out_ready4 = 1'b1;
      @(posedge clk); #1; out_ready4 = 1'b0;
      checks++;
      if (out_valid4 !== 1'b0 || in_ready4 !== 1'b1) begin
         errors++; $display("FAIL stall_release: got vld=%b rdy=%b want vld=0 rdy=1", out_valid4, in_ready4);
      end
      @(posedge clk); #1;
      checks++;
      if (in_ready4 !== 1'b1 || out_valid4 !== 1'b0) begin
         errors++; $display("FAIL stall_no_reload: got rdy=%b vld=%b want rdy=1 vld=0", in_ready4, out_valid4);
      end
   endtask

   task automatic test_rst_mid_run;
      int lat;
      send4(4'b0100, 4'b0001);
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      checks++;
      if (in_ready4 !== 1'b1 || out_valid4 !== 1'b0 || out_mag4 !== 8'h00 || out_sign4 !== 2'b00 || out_zero4 !== 1'b0) begin
         errors++;
         $display("FAIL midrun_reset: rdy=%b vld=%b mag=%b sign=%b zero=%b, want rdy=1 vld=0 mag=0 sign=00 zero=0",
                  in_ready4, out_valid4, out_mag4, out_sign4, out_zero4);
      end
      send4(4'b0100, 4'b0001);
      wait_valid4(lat);
      checks++;
      if (lat !== 4 || out_mag4 !== 8'b00_10_00_01 || out_sign4 !== 2'b10 || out_zero4 !== 1'b0) begin
         errors++;
         $display("FAIL after_reset_pos3: got lat=%0d mag=%b sign=%b zero=%b want lat=4 mag=00100001 sign=10 zero=0",
                  lat, out_mag4, out_sign4, out_zero4);
      end
      release4;
   endtask

   function automatic int operand_value(input logic [7:0] ps, input logic [7:0] tr);
      int s = 0;
      for (int i = 0; i < 8; i++) s += ((ps[i] ? 1 : 0) - (tr[i] ? 1 : 0)) * (1 << i);
      return s;
   endfunction

   function automatic int mag_value(input logic [15:0] mag);
      int s = 0;
      for (int i = 0; i < 8; i++) s += ((mag[2*i+1] ? 1 : 0) - (mag[2*i] ? 1 : 0)) * (1 << i);
      return s;
   endfunction

   function automatic logic mag_has_zero2(input logic [15:0] mag);
      logic bad = 1'b0;
      for (int i = 0; i < 8; i++) if (mag[2*i +: 2] == 2'b11) bad = 1'b1;
      return bad;
   endfunction

   task automatic test_random;
      int exp_q[$];
      fork
         begin : driver
            logic [7:0] ps, tr;
            int wt;
            for (int k = 0; k < 1000; k++) begin
               @(negedge clk);
               in_valid8 = 1'b0;
               repeat ($urandom_range(0, 2)) @(negedge clk);
               ps = 8'($urandom); tr = 8'($urandom);
               in_ps8 = ps; in_tr8 = tr; in_valid8 = 1'b1;
               wt = 0;
               while (!in_ready8 && wt < 100) begin @(negedge clk); wt++; end
               if (wt >= 100) begin
                  checks++; errors++;
                  $display("FAIL rand_accept_timeout: operand %0d in_ready=%b want 1 within 100 cycles", k, in_ready8);
                  break;
               end
               exp_q.push_back(operand_value(ps, tr));
            end
            @(negedge clk); in_valid8 = 1'b0;
         end
         begin : monitor
            int nrx = 0;
            int idle = 0;
            int x, mv;
            logic ok;
            while (nrx < 1000 && idle < 200) begin
               @(negedge clk);
               out_ready8 = ($urandom_range(0, 3) != 0);
               if (out_valid8 && out_ready8) begin
                  idle = 0;
                  checks++;
                  if (exp_q.size() == 0) begin
                     errors++; $display("FAIL rand_spurious: result with no operand outstanding, mag=%h", out_mag8);
                  end else begin
                     x  = exp_q.pop_front();
                     mv = mag_value(out_mag8);
                     if (x == 0) ok = (out_sign8 === 2'b00) && (out_zero8 === 1'b1) && (mv == 0);
                     else        ok = (out_sign8 === (x > 0 ? 2'b10 : 2'b01)) && (out_zero8 === 1'b0) &&
                                      (mv == (x > 0 ? x : -x));
                     if (mag_has_zero2(out_mag8)) ok = 1'b0;
                     if (!ok) begin
                        errors++;
                        $display("FAIL rand_result%0d: got mag=%h(val %0d) sign=%b zero=%b want x=%0d", nrx, out_mag8, mv,
                                 out_sign8, out_zero8, x);
                     end
                  end
                  nrx++;
               end else begin
                  idle++;
               end
            end
            out_ready8 = 1'b0;
            if (nrx < 1000) begin
               checks++; errors++;
               $display("FAIL rand_timeout: got %0d results want 1000", nrx);
            end
         end
      join
   endtask

   initial begin
      #3000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      in_valid4 = 1'b0; out_ready4 = 1'b0; in_ps4 = '0; in_tr4 = '0;
      in_valid8 = 1'b0; out_ready8 = 1'b0; in_ps8 = '0; in_tr8 = '0;
      test_reset();
      test_pos3();
      test_neg3();
      test_all_zero2();
      test_backpressure();
      test_rst_mid_run();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
